// File: rtl/alu_issue_queue_if.sv
// Shared packet types and the dispatch/broadcast/issue bus of the ALU issue queue.
// The queue attaches through the slave modport. The producer side uses the master modport.
package alu_issue_queue_pkg;
    localparam int TAG_BITS = 6;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic                is_valid;
        logic [3:0]          opcode;
        logic [TAG_BITS-1:0] dest_reg;
        logic [XLEN-1:0]     src_0_a;
        logic                src_0_a_rdy;
        logic [XLEN-1:0]     src_0_b;
        logic                src_0_b_rdy;
        logic [XLEN-1:0]     src_1_a;
        logic                src_1_a_rdy;
        logic [XLEN-1:0]     src_1_b;
        logic                src_1_b_rdy;
    } instruction_t;

    typedef struct packed {
        logic                is_valid;
        logic [TAG_BITS-1:0] dest_reg;
        logic [XLEN-1:0]     result;
    } writeback_packet_t;
endpackage

interface alu_issue_queue_if
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CDB_PORTS = 2
);
    logic                                flush;
    logic                                dis_valid;
    instruction_t                        dis_packet;
    logic                                dis_rdy;
    logic              [CDB_PORTS-1:0]   cdb_valid;
    writeback_packet_t [CDB_PORTS-1:0]   cdb_result;
    instruction_t                        alu_packet;
    logic                                alu_rdy;
    logic              [$clog2(DEPTH):0] count;

    modport master (
        output flush, dis_valid, dis_packet, cdb_valid, cdb_result, alu_rdy,
        input  dis_rdy, alu_packet, count
    );

    modport slave (
        input  flush, dis_valid, dis_packet, cdb_valid, cdb_result, alu_rdy,
        output dis_rdy, alu_packet, count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// The ALU issue queue keeps entries in age order and snoops the CDB to wake up operands.
// Each cycle it issues the oldest ready entry and then compacts the queue.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CDB_PORTS = 2
) (
    input logic              clk,
    input logic              rst,
    alu_issue_queue_if.slave io
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    instruction_t         entries_q [DEPTH];
    instruction_t         entries_d [DEPTH];
    instruction_t         woken     [DEPTH];
    instruction_t         dis_woken;
    instruction_t         alu_packet;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     count_after_issue;
    logic                 hold_q, hold_d;
    logic [IDX_W-1:0]     hold_idx_q, hold_idx_d;
    logic [DEPTH-1:0]     ready;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic                 dis_rdy;
    logic                 accept;
    logic                 issue_fire;

    function automatic logic [XLEN:0] wake_op(
        input logic [XLEN-1:0]                     data,
        input logic                                rdy,
        input logic [CDB_PORTS-1:0]                cv,
        input writeback_packet_t [CDB_PORTS-1:0]   cr
    );
        logic [XLEN:0] r;
        r = {rdy, data};
        if (!rdy) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cv[p] && cr[p].is_valid && cr[p].dest_reg == data[TAG_BITS-1:0]) begin
                    r = {1'b1, cr[p].result};
                end
            end
        end
        return r;
    endfunction

    function automatic instruction_t wake_inst(
        input instruction_t                        e,
        input logic [CDB_PORTS-1:0]                cv,
        input writeback_packet_t [CDB_PORTS-1:0]   cr
    );
        instruction_t w;
        w = e;
        {w.src_0_a_rdy, w.src_0_a} = wake_op(e.src_0_a, e.src_0_a_rdy, cv, cr);
        {w.src_0_b_rdy, w.src_0_b} = wake_op(e.src_0_b, e.src_0_b_rdy, cv, cr);
        {w.src_1_a_rdy, w.src_1_a} = wake_op(e.src_1_a, e.src_1_a_rdy, cv, cr);
        {w.src_1_b_rdy, w.src_1_b} = wake_op(e.src_1_b, e.src_1_b_rdy, cv, cr);
        return w;
    endfunction

    // A stalled issue keeps its slot index, so alu_packet stays stable until the ALU takes it.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (CNT_W'(i) < count_q) && entries_q[i].src_0_a_rdy && entries_q[i].src_0_b_rdy
                       && entries_q[i].src_1_a_rdy && entries_q[i].src_1_b_rdy;
        end
        sel_found = 1'b0;
        sel_idx   = '0;
        if (hold_q) begin
            sel_found = 1'b1;
            sel_idx   = hold_idx_q;
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ready[i]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
        if (io.flush) begin
            sel_found = 1'b0;
        end
        alu_packet = '0;
        if (sel_found) begin
            alu_packet          = entries_q[sel_idx];
            alu_packet.is_valid = 1'b1;
        end
    end

    assign dis_rdy       = (count_q < CNT_W'(DEPTH)) && !io.flush;
    assign accept        = io.dis_valid && dis_rdy;
    assign issue_fire    = sel_found && io.alu_rdy;
    assign io.dis_rdy    = dis_rdy;
    assign io.alu_packet = alu_packet;
    assign io.count      = count_q;

    // Wakeup is applied before compaction so a shifted entry keeps any data captured this cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake_inst(entries_q[i], io.cdb_valid, io.cdb_result);
        end
        dis_woken         = wake_inst(io.dis_packet, io.cdb_valid, io.cdb_result);
        count_after_issue = count_q - CNT_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = woken[i];
            if (issue_fire && IDX_W'(i) >= sel_idx) begin
                if (i == DEPTH - 1) begin
                    entries_d[i] = '0;
                end else begin
                    entries_d[i] = woken[(i + 1) % DEPTH];
                end
            end
        end
        if (accept) begin
            entries_d[count_after_issue[IDX_W-1:0]] = dis_woken;
        end
        count_d    = count_after_issue + CNT_W'(accept);
        hold_d     = sel_found && !io.alu_rdy;
        hold_idx_d = sel_idx;
        if (io.flush) begin
            count_d = '0;
            hold_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q    <= count_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// This testbench drives directed and random stimulus into alu_issue_queue.
// It checks the DUT against an age-ordered queue model kept in the bench.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    alu_issue_queue_if #(.DEPTH(DEPTH), .CDB_PORTS(2)) io ();

    alu_issue_queue #(.DEPTH(DEPTH), .CDB_PORTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    logic                    s_dv, s_flush, s_rst, s_ardy;
    instruction_t            s_pkt;
    logic [1:0]              s_cv;
    writeback_packet_t [1:0] s_cdb;

    instruction_t model_q[$];
    int           model_hold = -1;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic all_rdy(input instruction_t e);
        return e.src_0_a_rdy && e.src_0_b_rdy && e.src_1_a_rdy && e.src_1_b_rdy;
    endfunction

    // Each operand that is still waiting takes the result of any valid broadcast carrying its tag.
    function automatic instruction_t model_wake(input instruction_t e);
        logic [31:0] d[4];
        logic        r[4];
        logic        hit;
        d[0] = e.src_0_a; r[0] = e.src_0_a_rdy;
        d[1] = e.src_0_b; r[1] = e.src_0_b_rdy;
        d[2] = e.src_1_a; r[2] = e.src_1_a_rdy;
        d[3] = e.src_1_b; r[3] = e.src_1_b_rdy;
        for (int k = 0; k < 4; k++) begin
            hit = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (!r[k] && !hit && s_cv[p] && s_cdb[p].is_valid
                    && s_cdb[p].dest_reg == d[k][TAG_BITS-1:0]) begin
                    d[k] = s_cdb[p].result;
                    hit  = 1'b1;
                end
            end
            if (hit) r[k] = 1'b1;
        end
        e.src_0_a = d[0]; e.src_0_a_rdy = r[0];
        e.src_0_b = d[1]; e.src_0_b_rdy = r[1];
        e.src_1_a = d[2]; e.src_1_a_rdy = r[2];
        e.src_1_b = d[3]; e.src_1_b_rdy = r[3];
        return e;
    endfunction

    function automatic instruction_t make_pkt(input logic [3:0] opc, input logic [3:0] rdy_mask,
                                              input logic [23:0] tags);
        instruction_t p;
        logic [31:0]  d[4];
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom;
            if (!rdy_mask[k]) d[k][5:0] = tags[6*k +: 6];
        end
        p             = '0;
        p.is_valid    = 1'b1;
        p.opcode      = opc;
        p.dest_reg    = 6'($urandom_range(0, 63));
        p.src_0_a     = d[0]; p.src_0_a_rdy = rdy_mask[0];
        p.src_0_b     = d[1]; p.src_0_b_rdy = rdy_mask[1];
        p.src_1_a     = d[2]; p.src_1_a_rdy = rdy_mask[2];
        p.src_1_b     = d[3]; p.src_1_b_rdy = rdy_mask[3];
        return p;
    endfunction

    task automatic clearStimulus();
        s_dv = 1'b0; s_flush = 1'b0; s_rst = 1'b0; s_ardy = 1'b1;
        s_pkt = '0; s_cv = '0; s_cdb = '0;
    endtask

    // The DUT outputs are sampled mid-cycle. Afterwards the model advances past the next rising edge.
    task automatic applyStimulus();
        instruction_t exp_alu;
        logic         exp_rdy;
        int           sel;
        @(negedge clk);
        io.flush = s_flush; io.dis_valid = s_dv; io.dis_packet = s_pkt;
        io.cdb_valid = s_cv; io.cdb_result = s_cdb; io.alu_rdy = s_ardy; rst = s_rst;
        #1;
        exp_rdy = (model_q.size() < DEPTH) && !s_flush;
        sel = -1;
        if (!s_flush) begin
            if (model_hold >= 0) sel = model_hold;
            else foreach (model_q[i]) if (sel < 0 && all_rdy(model_q[i])) sel = i;
        end
        exp_alu = '0;
        if (sel >= 0) begin
            exp_alu = model_q[sel];
            exp_alu.is_valid = 1'b1;
        end
        checkOutput("count", 256'(io.count), 256'(model_q.size()));
        checkOutput("dis_rdy", 256'(io.dis_rdy), 256'(exp_rdy));
        checkOutput("alu_packet", 256'(io.alu_packet), 256'(exp_alu));
        if (s_rst || s_flush) begin
            model_q.delete();
            model_hold = -1;
        end else begin
            foreach (model_q[i]) model_q[i] = model_wake(model_q[i]);
            if (sel >= 0 && s_ardy) begin
                model_q.delete(sel);
                model_hold = -1;
            end else begin
                model_hold = sel;
            end
            if (s_dv && exp_rdy) model_q.push_back(model_wake(s_pkt));
        end
    endtask

    task automatic randomStimulus();
        logic [23:0] tags;
        logic [3:0]  mask;
        for (int k = 0; k < 4; k++) begin
            tags[6*k +: 6] = 6'($urandom_range(0, 7));
            mask[k]        = ($urandom_range(0, 2) != 0);
        end
        s_dv    = ($urandom_range(0, 9) < 6);
        s_pkt   = make_pkt(4'($urandom_range(0, 15)), mask, tags);
        s_ardy  = ($urandom_range(0, 9) < 7);
        s_flush = ($urandom_range(0, 49) == 0);
        s_rst   = ($urandom_range(0, 99) == 0);
        for (int p = 0; p < 2; p++) begin
            s_cv[p]              = 1'($urandom_range(0, 1));
            s_cdb[p].is_valid    = ($urandom_range(0, 4) != 0);
            s_cdb[p].dest_reg    = 6'($urandom_range(0, 7));
            s_cdb[p].result      = $urandom;
        end
        if (s_cdb[1].dest_reg == s_cdb[0].dest_reg) s_cdb[1].dest_reg = s_cdb[0].dest_reg + 6'd8;
    endtask

    initial begin
        clearStimulus();
        rst = 1'b1;
        io.flush = 1'b0; io.dis_valid = 1'b0; io.dis_packet = '0;
        io.cdb_valid = '0; io.cdb_result = '0; io.alu_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // The first sampled cycle shows the state just after reset.
        clearStimulus(); applyStimulus();

        // An all-ready ADD is issued the cycle after dispatch, and the queue then empties.
        s_dv = 1'b1; s_pkt = make_pkt(4'd1, 4'hF, 24'd0); applyStimulus();
        clearStimulus(); applyStimulus();
        checkOutput("add_issue_valid", 256'(io.alu_packet.is_valid), 256'(1));
        clearStimulus(); applyStimulus();
        checkOutput("add_count_zero", 256'(io.count), 256'(0));

        // A CDB result on port 1 wakes tag 5. The entry is issued in the cycle after the broadcast.
        s_dv = 1'b1; s_pkt = make_pkt(4'd2, 4'b1110, 24'd5); applyStimulus();
        clearStimulus();
        s_cv[1] = 1'b1; s_cdb[1].is_valid = 1'b1; s_cdb[1].dest_reg = 6'd5; s_cdb[1].result = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("wake_not_same_cycle", 256'(io.alu_packet.is_valid), 256'(0));
        clearStimulus(); applyStimulus();
        checkOutput("wake_issue_valid", 256'(io.alu_packet.is_valid), 256'(1));
        checkOutput("wake_issue_data", 256'(io.alu_packet.src_0_a), 256'(32'hDEADBEEF));
        clearStimulus(); applyStimulus();

        // A broadcast in the same cycle as the dispatch wakes the incoming operand.
        s_dv = 1'b1; s_pkt = make_pkt(4'd3, 4'b0111, {6'd7, 18'd0});
        s_cv[0] = 1'b1; s_cdb[0].is_valid = 1'b1; s_cdb[0].dest_reg = 6'd7; s_cdb[0].result = 32'h12345678;
        applyStimulus();
        clearStimulus(); applyStimulus();
        checkOutput("bypass_issue_valid", 256'(io.alu_packet.is_valid), 256'(1));
        checkOutput("bypass_issue_data", 256'(io.alu_packet.src_1_b), 256'(32'h12345678));
        clearStimulus(); applyStimulus();

        // With eight entries the queue is full, so a ninth dispatch is dropped. One issue reopens the queue.
        for (int k = 0; k < DEPTH; k++) begin
            clearStimulus(); s_ardy = 1'b0; s_dv = 1'b1; s_pkt = make_pkt(4'(k), 4'hF, 24'd0);
            applyStimulus();
        end
        clearStimulus(); s_ardy = 1'b0; s_dv = 1'b1; s_pkt = make_pkt(4'd9, 4'hF, 24'd0);
        applyStimulus();
        checkOutput("full_dis_rdy", 256'(io.dis_rdy), 256'(0));
        checkOutput("full_count", 256'(io.count), 256'(8));
        clearStimulus(); applyStimulus();
        clearStimulus(); s_ardy = 1'b0; applyStimulus();
        checkOutput("after_issue_count", 256'(io.count), 256'(7));
        checkOutput("after_issue_dis_rdy", 256'(io.dis_rdy), 256'(1));
        for (int k = 0; k < 10; k++) begin
            clearStimulus(); applyStimulus();
        end

        // Younger ready entries pass an older blocked entry, and the compacted slot is issued next.
        clearStimulus(); s_ardy = 1'b0; s_dv = 1'b1; s_pkt = make_pkt(4'd1, 4'b1110, 24'd40); applyStimulus();
        s_pkt = make_pkt(4'd2, 4'hF, 24'd0); applyStimulus();
        s_pkt = make_pkt(4'd3, 4'hF, 24'd0); applyStimulus();
        clearStimulus(); applyStimulus();
        checkOutput("prio_first", 256'(io.alu_packet.opcode), 256'(2));
        clearStimulus(); applyStimulus();
        checkOutput("prio_second", 256'(io.alu_packet.opcode), 256'(3));
        checkOutput("prio_count", 256'(io.count), 256'(2));
        clearStimulus(); applyStimulus();
        checkOutput("prio_retained", 256'(io.count), 256'(1));
        checkOutput("prio_blocked", 256'(io.alu_packet.is_valid), 256'(0));
        clearStimulus(); s_flush = 1'b1; applyStimulus();

        // A flush or reset with four entries held discards the queue and the incoming dispatch.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                clearStimulus(); s_ardy = 1'b0; s_dv = 1'b1;
                s_pkt = make_pkt(4'(k), 4'b1110, 24'(50 + k));
                applyStimulus();
            end
            clearStimulus(); s_dv = 1'b1; s_pkt = make_pkt(4'd9, 4'hF, 24'd0);
            if (pass == 0) s_flush = 1'b1; else s_rst = 1'b1;
            applyStimulus();
            if (pass == 0) checkOutput("flush_no_issue", 256'(io.alu_packet.is_valid), 256'(0));
            clearStimulus(); applyStimulus();
            checkOutput("squash_count", 256'(io.count), 256'(0));
            checkOutput("squash_no_issue", 256'(io.alu_packet.is_valid), 256'(0));
        end

        for (int n = 0; n < 800; n++) begin
            randomStimulus();
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of 2, >=2).
REQ-002 SHALL have parameter CDB_PORTS, default 2, number of result-broadcast ports snooped for wakeup.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous squash of all entries.
REQ-006 SHALL have port dis_valid  input  1  dispatch offers one instruction.
REQ-007 SHALL have port dis_packet  input  $bits(instruction_t)  dispatched instruction; per operand X in {src_0_a, src_0_b, src_1_a, src_1_b}: X (data or tag in low TAG_BITS), X_rdy (1 = data valid).
REQ-008 SHALL have port dis_rdy  output  1  queue accepts dispatch this cycle.
REQ-009 SHALL have port cdb_valid  input  CDB_PORTS  per-port broadcast valid.
REQ-010 SHALL have port cdb_result  input  CDB_PORTS x $bits(writeback_packet_t)  broadcast packets; dest_reg is the tag, result the data.
REQ-011 SHALL have port alu_packet  output  $bits(instruction_t)  instruction issued to the ALU; is_valid marks a real issue.
REQ-012 SHALL have port alu_rdy  input  1  ALU accepts alu_packet this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 SHALL store entries in age order, slot 0 oldest, slots 0..count-1 occupied, no holes.
REQ-015 SHALL assert dis_rdy = (count < DEPTH) && !flush, from registered count only (no same-cycle issue credit).
REQ-016 SHALL write dis_packet into slot count (post-compaction) on edge where dis_valid && dis_rdy; dis_valid with dis_rdy low SHALL be ignored.
REQ-017 SHALL, per stored operand with X_rdy=0, compare low TAG_BITS of X with dest_reg of every cdb port with cdb_valid && is_valid; on match, set X := result and X_rdy := 1 at the edge.
REQ-018 SHALL apply the same wakeup to dis_packet operands in its dispatch cycle, so a result broadcast in that cycle is not lost.
REQ-019 SHALL treat an entry as ready when all four X_rdy bits are 1 in registered state; wakeup in cycle N makes the entry issuable in cycle N+1 at earliest.
REQ-020 SHALL drive alu_packet combinationally with the lowest-index ready entry, is_valid=1; if none ready, alu_packet is all zeros with is_valid=0.
REQ-021 SHALL remove the selected entry on edge where alu_rdy && alu_packet.is_valid, shifting younger entries down one slot; alu_packet SHALL be held stable while alu_rdy is low.
REQ-022 SHALL support dispatch, issue and wakeup in the same cycle; count next = count + accept - issue.
REQ-023 SHALL apply wakeup to entries during the shift, so a shifted entry keeps its matched data.
REQ-024 SHALL, on flush, empty the queue at the edge (count := 0), discard any same-cycle dispatch, and suppress issue (alu_packet.is_valid=0) in the flush cycle.
REQ-025 SHALL ignore cdb ports with cdb_valid=0 regardless of packet content.
REQ-026 SHALL hold a one-hot-by-priority selection: at most one entry issued per cycle.

Reset
REQ-027 SHALL, on rst, set count=0, clear all entry valid/ready state, drive dis_rdy=1 the following cycle, alu_packet.is_valid=0.
REQ-028 SHALL give rst priority over flush, dispatch, wakeup and issue in the same cycle.

Verification
REQ-029 Dispatch ADD all operands ready, alu_rdy=1 -> alu_packet.is_valid=1 next cycle, count back to 0 after that edge.
REQ-030 Dispatch entry with src_0_a tag 5 not ready; cycle N cdb_valid[1]=1, dest_reg=5, result=0xDEADBEEF -> issue in N+1 with src_0_a=0xDEADBEEF.
REQ-031 Fill 8 entries, alu_rdy=0 -> dis_rdy=0, 9th dispatch dropped, count=8; alu_rdy=1 one cycle -> count=7, dis_rdy=1.
REQ-032 Entries 0 (not ready), 1 (ready), 2 (ready) -> slot 1 issues first, then slot 2 (shifted to slot 1); slot 0 retained.
REQ-033 Dispatch with tag 7 while cdb broadcasts tag 7 same cycle -> entry stored ready, issued next cycle.
REQ-034 Four entries held, flush with dis_valid=1 -> count=0 next cycle, no issue, dispatched instruction absent; rst mid-operation identical.
